wash_act_drv: RTL
=================

# wash_act_drv

Actuator driver that sits directly downstream of the washing-machine sequencer. It consumes the sequencer's 3-bit `mode` code (0 standby, 1 fill, 2 rinse, 3 wash, 4 spin) and drives the physical outputs: water valve, drain pump, motor enable/direction/PWM and door lock. It also supervises the door, flags faults, and counts completed cycles.

## Interface
- `AGIT_PERIOD`, 4: cycles per motor direction during wash agitation (≥1).
- `PWM_BITS`, 3: width of the spin PWM counter; the full-on duty is 2^PWM_BITS.
- `RAMP_STEP`, 2: cycles between spin duty increments (≥1).
- `UNLOCK_DELAY`, 3: cycles the door stays locked after returning to standby (≥1).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode` input 3: sequencer state code; values 5–7 are illegal.
- `door_closed` input 1: door switch, 1 = closed.
- `valve_on` output 1: inlet water valve.
- `drain_on` output 1: drain pump.
- `motor_on` output 1: motor enable.
- `motor_dir` output 1: 0 = clockwise, 1 = counter-clockwise.
- `motor_pwm` output 1: motor drive gate; meaningful only while `motor_on` is 1.
- `door_lock` output 1: door latch solenoid.
- `cycle_done` output 1: one-cycle pulse on completion of a full cycle.
- `fault` output 1: sticky fault flag.
- `cycle_count` output 8: number of completed cycles, saturating.

## Operation
- All outputs are registered. Internal state:
  - `prev_mode` register (3 bits).
  - Agitation counter and direction register.
  - PWM counter (PWM_BITS bits) and duty register (PWM_BITS+1 bits).
  - Unlock down-counter.
- Effective mode:
  - Illegal `mode` values (5–7) are decoded as standby and set `fault`.
  - While `fault` = 1, the effective mode is standby for all actuators.
- Decode per effective mode:
  - standby: all actuators off.
  - fill: `valve_on` = 1.
  - rinse: `drain_on` = 1, `motor_on` = 1, `motor_dir` = 0, `motor_pwm` = 1.
  - wash: `motor_on` = 1, `motor_pwm` = 1, `motor_dir` toggles every AGIT_PERIOD cycles, starting at 0 on wash entry.
  - spin: `drain_on` = 1, `motor_on` = 1, `motor_dir` = 0, `motor_pwm` = (pwm_cnt < duty).
- Spin ramp:
  - On spin entry, duty = 1 and pwm_cnt = 0.
  - duty increments every RAMP_STEP cycles and saturates at 2^PWM_BITS, at which point `motor_pwm` is constant 1.
  - pwm_cnt is free-running and wraps.
- Door lock:
  - `door_lock` = 1 whenever the effective mode is not standby.
  - On return to standby, the lock is held a further UNLOCK_DELAY cycles, then released.
  - Re-entering a non-standby mode during the delay keeps the lock asserted and cancels the countdown.
- Door fault:
  - `door_closed` = 0 while `mode` ≠ standby sets `fault`.
  - `fault` clears only when `mode` = standby and `door_closed` = 1 on the same edge, or by reset.
  - `door_lock` still obeys the unlock delay after a fault.
- Cycle completion:
  - `prev_mode` = 4 and `mode` = 0, with `fault` = 0, pulses `cycle_done` for one cycle.
  - The same event increments `cycle_count`, which saturates at 255.
  - Any other path back to standby (e.g. fill→standby on a sequencer abort) gives no pulse.
- Mode change mid-phase: the agitation counter and the spin ramp restart on every entry into their mode; nothing is retained across an exit.

## Timing
- Latency is 1 cycle: a `mode` change sampled at edge N is reflected on the outputs after edge N.
- A door fault forces the actuators off after the same edge that samples `door_closed` = 0.
- `cycle_done` is asserted in the cycle after the edge that samples the 4→0 transition. `cycle_count` updates on that same edge.
- Reset (asynchronous, mid-operation allowed): all outputs go to 0, including `door_lock`, `fault`, `cycle_done` and `cycle_count`; `prev_mode` = 0; all counters = 0.

## Configuration
- Macro `WASH_ACT_DRV_AGIT_EN`.
  - Defined: wash-mode direction toggling is active as described above.
  - Undefined: the agitation counter is not built, and `motor_dir` is held at 0 in wash.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then `mode` = 1 → `valve_on` = 1 one cycle later; all other outputs 0 except `door_lock` = 1.
- `mode` = 3 held 12 cycles (AGIT_PERIOD = 4) → `motor_dir` sequence 0000 1111 0000; with the macro undefined, all 0.
- `mode` = 4 (PWM_BITS = 3, RAMP_STEP = 2) → duty steps 1, 2, … 8, one step every 2 cycles; `motor_pwm` is constant 1 from duty 8.
- Sequence 1 → 2 → 3 → 4 → 0 → `cycle_done` pulses once; `cycle_count` goes 0→1; `door_lock` drops 3 cycles after standby.
- `door_closed` = 0 during wash → `fault` = 1 and actuators off next cycle; `fault` persists until `mode` = 0 with `door_closed` = 1; the subsequent 4→0 gives no pulse while faulted.
- `mode` = 6 → `fault` = 1, outputs as standby; `rst_n` asserted mid-spin → all outputs 0 immediately.

Source files
------------

// File: rtl/wash_act_drv_if.sv
// Sequencer-to-actuator bundle for wash_act_drv.
//   mode, door_closed          : sequencer/door inputs to the driver
//   valve_on .. door_lock      : physical actuator drives
//   cycle_done, fault          : status pulse and sticky fault flag
//   cycle_count                : saturating count of completed cycles
// master = sequencer side, slave = actuator driver.
interface wash_act_drv_if;
    logic [2:0] mode;
    logic       door_closed;
    logic       valve_on;
    logic       drain_on;
    logic       motor_on;
    logic       motor_dir;
    logic       motor_pwm;
    logic       door_lock;
    logic       cycle_done;
    logic       fault;
    logic [7:0] cycle_count;

    modport master (
        output mode, door_closed,
        input  valve_on, drain_on, motor_on, motor_dir, motor_pwm,
        input  door_lock, cycle_done, fault, cycle_count
    );

    modport slave (
        input  mode, door_closed,
        output valve_on, drain_on, motor_on, motor_dir, motor_pwm,
        output door_lock, cycle_done, fault, cycle_count
    );
endinterface

// File: rtl/wash_act_drv.sv
// Washing-machine actuator driver: decodes the sequencer mode into valve,
// drain, motor and door-lock drives, supervises the door, flags faults and
// counts completed wash cycles. All outputs are registered (1-cycle latency).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : wash_act_drv_if.slave (mode/door_closed in, actuators/status out)
// Build option: define WASH_ACT_DRV_AGIT_EN to enable wash-mode direction
// agitation; otherwise motor_dir stays 0 in wash and no agitation counter exists.
module wash_act_drv #(
    parameter int unsigned AGIT_PERIOD  = 4,
    parameter int unsigned PWM_BITS     = 3,
    parameter int unsigned RAMP_STEP    = 2,
    parameter int unsigned UNLOCK_DELAY = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    wash_act_drv_if.slave  bus
);

    localparam int unsigned DUTY_W = PWM_BITS + 1;
    localparam int unsigned RAMP_W = $clog2(RAMP_STEP + 1);
    localparam int unsigned UNLK_W = $clog2(UNLOCK_DELAY + 1);

    localparam logic [2:0] MODE_STBY  = 3'd0;
    localparam logic [2:0] MODE_FILL  = 3'd1;
    localparam logic [2:0] MODE_RINSE = 3'd2;
    localparam logic [2:0] MODE_WASH  = 3'd3;
    localparam logic [2:0] MODE_SPIN  = 3'd4;

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(2 ** PWM_BITS);

    logic [2:0]          prev_mode_q, prev_mode_d;
    logic [2:0]          eff_q, eff_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [UNLK_W-1:0]   unlock_q, unlock_d;
    logic                valve_q, valve_d;
    logic                drain_q, drain_d;
    logic                motor_on_q, motor_on_d;
    logic                motor_dir_q, motor_dir_d;
    logic                motor_pwm_q, motor_pwm_d;
    logic                lock_q, lock_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [7:0]          count_q, count_d;

`ifdef WASH_ACT_DRV_AGIT_EN
    localparam int unsigned AGIT_W = $clog2(AGIT_PERIOD + 1);
    logic [AGIT_W-1:0]   agit_cnt_q, agit_cnt_d;

    // Agitation counter: cycles spent in the current direction (1-based)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) agit_cnt_q <= '0;
        else        agit_cnt_q <= agit_cnt_d;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mode_q <= '0;
            eff_q       <= '0;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            ramp_cnt_q  <= '0;
            unlock_q    <= '0;
            valve_q     <= 1'b0;
            drain_q     <= 1'b0;
            motor_on_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            motor_pwm_q <= 1'b0;
            lock_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            prev_mode_q <= prev_mode_d;
            eff_q       <= eff_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            ramp_cnt_q  <= ramp_cnt_d;
            unlock_q    <= unlock_d;
            valve_q     <= valve_d;
            drain_q     <= drain_d;
            motor_on_q  <= motor_on_d;
            motor_dir_q <= motor_dir_d;
            motor_pwm_q <= motor_pwm_d;
            lock_q      <= lock_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    // Next-state decode
    always_comb begin
        prev_mode_d = bus.mode;
        fault_d     = fault_q;
        eff_d       = MODE_STBY;
        pwm_cnt_d   = '0;
        duty_d      = '0;
        ramp_cnt_d  = '0;
        unlock_d    = '0;
        valve_d     = 1'b0;
        drain_d     = 1'b0;
        motor_on_d  = 1'b0;
        motor_dir_d = 1'b0;
        motor_pwm_d = 1'b0;
        lock_d      = 1'b0;
        done_d      = 1'b0;
        count_d     = count_q;
`ifdef WASH_ACT_DRV_AGIT_EN
        agit_cnt_d  = '0;
`endif

        // Fault is set and cleared on the sampling edge, so a door opening
        // shuts the actuators down without waiting an extra cycle.
        if ((bus.mode > MODE_SPIN) || (!bus.door_closed && (bus.mode != MODE_STBY))) begin
            fault_d = 1'b1;
        end else if ((bus.mode == MODE_STBY) && bus.door_closed) begin
            fault_d = 1'b0;
        end
        eff_d = fault_d ? MODE_STBY : bus.mode;

        valve_d    = (eff_d == MODE_FILL);
        drain_d    = (eff_d == MODE_RINSE) || (eff_d == MODE_SPIN);
        motor_on_d = (eff_d == MODE_RINSE) || (eff_d == MODE_WASH) || (eff_d == MODE_SPIN);

        if ((eff_d == MODE_RINSE) || (eff_d == MODE_WASH)) begin
            motor_pwm_d = 1'b1;
        end

`ifdef WASH_ACT_DRV_AGIT_EN
        // Direction restarts at clockwise on every wash entry
        if (eff_d == MODE_WASH) begin
            if (eff_q != MODE_WASH) begin
                agit_cnt_d  = AGIT_W'(1);
                motor_dir_d = 1'b0;
            end else if (agit_cnt_q == AGIT_W'(AGIT_PERIOD)) begin
                agit_cnt_d  = AGIT_W'(1);
                motor_dir_d = ~motor_dir_q;
            end else begin
                agit_cnt_d  = agit_cnt_q + 1'b1;
                motor_dir_d = motor_dir_q;
            end
        end
`endif

        // Spin soft-start: duty ramps from 1 to full, restarting on every entry
        if (eff_d == MODE_SPIN) begin
            if (eff_q != MODE_SPIN) begin
                pwm_cnt_d  = '0;
                duty_d     = DUTY_W'(1);
                ramp_cnt_d = RAMP_W'(1);
            end else begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
                if (duty_q == DUTY_FULL) begin
                    duty_d     = duty_q;
                    ramp_cnt_d = ramp_cnt_q;
                end else if (ramp_cnt_q == RAMP_W'(RAMP_STEP)) begin
                    duty_d     = duty_q + 1'b1;
                    ramp_cnt_d = RAMP_W'(1);
                end else begin
                    duty_d     = duty_q;
                    ramp_cnt_d = ramp_cnt_q + 1'b1;
                end
            end
            motor_pwm_d = ({1'b0, pwm_cnt_d} < duty_d);
        end

        // Door lock with post-standby hold; any active mode cancels the hold
        if (eff_d != MODE_STBY) begin
            lock_d = 1'b1;
        end else if (eff_q != MODE_STBY) begin
            lock_d   = 1'b1;
            unlock_d = UNLK_W'(UNLOCK_DELAY - 1);
        end else if (unlock_q != '0) begin
            lock_d   = 1'b1;
            unlock_d = unlock_q - 1'b1;
        end

        // Only a clean spin-to-standby finish counts as a completed cycle
        if ((prev_mode_q == MODE_SPIN) && (bus.mode == MODE_STBY) && !fault_q) begin
            done_d = 1'b1;
            if (count_q != 8'hFF) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign bus.valve_on    = valve_q;
    assign bus.drain_on    = drain_q;
    assign bus.motor_on    = motor_on_q;
    assign bus.motor_dir   = motor_dir_q;
    assign bus.motor_pwm   = motor_pwm_q;
    assign bus.door_lock   = lock_q;
    assign bus.cycle_done  = done_q;
    assign bus.fault       = fault_q;
    assign bus.cycle_count = count_q;

endmodule
